route_flit_dispatcher: RTL and testbench

- Sequential stage directly downstream of the combinational route-decision logic.
- Takes each flit together with its 3-bit route mask (bit k set = forward to output port k) and writes the flit into one small FIFO per output port.
- Handles multicast (several mask bits set) atomically and drops flits whose mask is zero, counting them in a saturating counter.
- Each output port has its own valid/ready interface.

---
 rtl/route_flit_dispatcher.sv | 95 +++++++++
 tb/tb_route_flit_dispatcher.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/route_flit_dispatcher.sv
// Route flit dispatcher: writes each accepted flit into one FIFO per targeted output port.
// Multicast is all-or-nothing, and flits with a zero route mask are dropped and counted.
module route_flit_dispatcher #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    parameter  int CNT_W  = 8,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_route,
    input  logic [DATA_W-1:0]     in_data,
    output logic [2:0]            out_valid,
    input  logic [2:0]            out_ready,
    output logic [3*DATA_W-1:0]   out_data,
    output logic [3*LVL_W-1:0]    out_level,
    output logic [CNT_W-1:0]      drop_cnt
);

    localparam int                 NPORT    = 3;
    localparam int                 PTR_W    = $clog2(DEPTH);
    localparam logic [LVL_W-1:0]   FULL_LVL = LVL_W'(DEPTH);

    logic [NPORT-1:0] port_full;
    logic [NPORT-1:0] wr_en;
    logic [NPORT-1:0] rd_en;
    logic             accept;
    logic             drop;

    // Fullness uses only the registered occupancy, so a full port that is
    // dequeuing this cycle still blocks the input.
    always_comb begin
        // NOTE: assign a default before any condition so no latch is inferred.
        in_ready = 1'b0;
        if (!rst) begin
            in_ready = ~|(in_route & port_full);
        end
    end

    assign accept = in_valid && in_ready;
    assign wr_en  = accept ? in_route : '0;
    assign drop   = accept && (in_route == '0);
    assign rd_en  = out_valid & out_ready;

    for (genvar k = 0; k < NPORT; k++) begin : g_port
        logic [DATA_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [LVL_W-1:0]  level;

        // NOTE: storage is not reset; the pointers and level alone decide which entries are valid.
        always_ff @(posedge clk) begin
            if (wr_en[k]) begin
                mem[wr_ptr] <= in_data;
            end
        end

        always_ff @(posedge clk) begin
            // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (wr_en[k]) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd_en[k]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({wr_en[k], rd_en[k]})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
            end
        end

        assign port_full[k]                   = (level == FULL_LVL);
        assign out_valid[k]                   = (level != '0);
        assign out_level[k*LVL_W +: LVL_W]    = level;
        assign out_data[k*DATA_W +: DATA_W]   = out_valid[k] ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_route_flit_dispatcher.sv
// Scoreboard bench for route_flit_dispatcher: per-port expected queues are filled on accept
// and compared against out_data whenever the DUT dequeues.
module tb_route_flit_dispatcher;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 8;
    localparam int LVL_W  = 3;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [2:0]          in_route;
    logic [DATA_W-1:0]   in_data;
    logic [2:0]          out_valid;
    logic [2:0]          out_ready;
    logic [3*DATA_W-1:0] out_data;
    logic [3*LVL_W-1:0]  out_level;
    logic [CNT_W-1:0]    drop_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DATA_W-1:0] q [3][$];
    int exp_drop = 0;

    route_flit_dispatcher #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_route(in_route), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_level(out_level),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_ready(logic [2:0] r);
        for (int k = 0; k < 3; k++) begin
            if (r[k] && (q[k].size() >= DEPTH)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [DATA_W-1:0] port_data(int k);
        return out_data[k*DATA_W +: DATA_W];
    endfunction

    // One clock: compare handshake and dequeued heads against the model, then advance the model.
    task automatic tick();
        logic       exp_ready;
        logic       acc;
        logic [2:0] deq;
        #1;
        exp_ready = rst ? 1'b0 : model_ready(in_route);
        n_checks++;
        if (in_ready !== exp_ready)
            $display("FAIL in_ready t=%0t: got %b expected %b", $time, in_ready, exp_ready);
        else n_pass++;
        deq = '0;
        for (int k = 0; k < 3; k++) begin
            if (q[k].size() > 0 && out_ready[k]) begin
                deq[k] = 1'b1;
                n_checks++;
                if (port_data(k) !== q[k][0])
                    $display("FAIL head_port%0d t=%0t: got %h expected %h", k, $time, port_data(k), q[k][0]);
                else n_pass++;
            end
        end
        acc = !rst && in_valid && exp_ready;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 3; k++) q[k].delete();
            exp_drop = 0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (deq[k]) void'(q[k].pop_front());
                if (acc && in_route[k]) q[k].push_back(in_data);
            end
            if (acc && in_route == 3'b000 && exp_drop != 255) exp_drop++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_route = 3'b000; in_data = '0; out_ready = 3'b000;
        tick();
        #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        else n_pass++;
        tick();
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 3'b000 || out_level !== 9'd0 || drop_cnt !== 8'd0 || out_data !== 24'd0)
            $display("FAIL reset_state: got valid=%b level=%o drop=%0d data=%h expected all zero",
                     out_valid, out_level, drop_cnt, out_data);
        else n_pass++;
    endtask

    task automatic test_unicast();
        in_valid = 1'b1; in_route = 3'b001; in_data = 8'hA5;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 3'b001 || port_data(0) !== 8'hA5 || out_level !== {3'd0, 3'd0, 3'd1})
            $display("FAIL unicast: got valid=%b data0=%h level=%o expected 001/a5/001",
                     out_valid, port_data(0), out_level);
        else n_pass++;
        out_ready = 3'b001;
        tick();
        out_ready = 3'b000;
        n_checks++;
        if (out_valid !== 3'b000 || out_data !== 24'd0)
            $display("FAIL unicast_drain: got valid=%b data=%h expected 000/0", out_valid, out_data);
        else n_pass++;
    endtask

    task automatic test_multicast_fill();
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_route = 3'b111; in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        n_checks++;
        if (out_level !== {3'd4, 3'd4, 3'd4} || out_valid !== 3'b111)
            $display("FAIL fill_levels: got level=%o valid=%b expected 444/111", out_level, out_valid);
        else n_pass++;
        in_route = 3'b010; #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL full_blocks: got in_ready=%b expected 0", in_ready);
        else n_pass++;
        in_route = 3'b000; #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL zero_mask_ready: got in_ready=%b expected 1", in_ready);
        else n_pass++;
        tick();
        out_ready = 3'b010;
        for (int i = 0; i < 4; i++) tick();
        out_ready = 3'b000;
        n_checks++;
        if (out_level !== {3'd4, 3'd0, 3'd4})
            $display("FAIL drain_port1: got level=%o expected 404", out_level);
        else n_pass++;
    endtask

    task automatic test_full_dequeue();
        in_valid = 1'b1; in_route = 3'b100; in_data = 8'hC2; out_ready = 3'b100; #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL full_deq_ready: got in_ready=%b expected 0", in_ready);
        else n_pass++;
        tick();
        out_ready = 3'b000;
        n_checks++;
        if (out_level[8:6] !== 3'd3) $display("FAIL full_deq_level: got %0d expected 3", out_level[8:6]);
        else n_pass++;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_level[8:6] !== 3'd4) $display("FAIL full_deq_refill: got %0d expected 4", out_level[8:6]);
        else n_pass++;
    endtask

    task automatic test_partial_block();
        in_valid = 1'b1; in_route = 3'b011; in_data = 8'h5B;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (out_level[5:3] !== 3'd0) $display("FAIL partial_hold%0d: got level1=%0d expected 0", i, out_level[5:3]);
            else n_pass++;
        end
        out_ready = 3'b001;
        tick();
        out_ready = 3'b000;
        n_checks++;
        if (out_level[5:0] !== {3'd0, 3'd3})
            $display("FAIL partial_free: got level1/0=%o expected 03", out_level[5:0]);
        else n_pass++;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_level[5:0] !== {3'd1, 3'd4})
            $display("FAIL partial_write: got level1/0=%o expected 14", out_level[5:0]);
        else n_pass++;
        out_ready = 3'b111;
        for (int i = 0; i < 5; i++) tick();
        out_ready = 3'b000;
        n_checks++;
        if (out_level !== 9'd0 || out_valid !== 3'b000)
            $display("FAIL partial_drain: got level=%o valid=%b expected 0", out_level, out_valid);
        else n_pass++;
    endtask

    task automatic test_drop_saturation();
        in_valid = 1'b1; in_route = 3'b000; in_data = 8'h3C;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 4) begin
                n_checks++;
                if (drop_cnt !== 8'd5) $display("FAIL drop_early: got %0d expected 5", drop_cnt);
                else n_pass++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (drop_cnt !== 8'd255 || drop_cnt !== 8'(exp_drop) || out_level !== 9'd0)
            $display("FAIL drop_sat: got drop=%0d level=%o expected 255/0", drop_cnt, out_level);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [2:0]        routes [3] = '{3'b111, 3'b011, 3'b010};
        logic [DATA_W-1:0] datas  [3] = '{8'h10, 8'h11, 8'h12};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_route = routes[i]; in_data = datas[i];
            tick();
        end
        n_checks++;
        if (out_level !== {3'd1, 3'd3, 3'd2})
            $display("FAIL mid_prefill: got level=%o expected 132", out_level);
        else n_pass++;
        rst = 1'b1; in_route = 3'b111; in_data = 8'hEE;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 3'b000 || out_level !== 9'd0 || out_data !== 24'd0 || drop_cnt !== 8'd0)
            $display("FAIL mid_reset: got valid=%b level=%o data=%h drop=%0d expected all zero",
                     out_valid, out_level, out_data, drop_cnt);
        else n_pass++;
        in_valid = 1'b1; in_route = 3'b100; in_data = 8'h77;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_level !== {3'd1, 3'd0, 3'd0} || port_data(2) !== 8'h77)
            $display("FAIL mid_new_traffic: got level=%o data2=%h expected 100/77", out_level, port_data(2));
        else n_pass++;
        out_ready = 3'b100;
        tick();
        out_ready = 3'b000;
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_multicast_fill();
        test_full_dequeue();
        test_partial_block();
        test_drop_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
